dcache_controller: RTL and testbench

Direct-mapped, write-back, write-allocate data cache controller between the CPU load/store path and the 32-bit-block data memory. Holds tag, valid, dirty and data arrays; uses a valid-qualified tag comparison to decide hit or miss. On a miss it runs write-back and fetch sequences on the memory side, stalling the CPU through BUSYWAIT.

---
 rtl/dcache_pkg.sv | 38 +++
 rtl/dcache_tag_cmp.sv | 13 +
 rtl/dcache_controller.sv | 159 +++++++++++++++
 tb/tb_dcache_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// Optional hit/miss statistics are enabled with DCACHE_STATS_EN.
package dcache_pkg;

  localparam int TAG_W     = 3;
  localparam int INDEX_W   = 3;
  localparam int OFFSET_W  = 2;
  localparam int NUM_LINES = 1 << INDEX_W;
  localparam int BLK_W     = 8 << OFFSET_W;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE_BACK = 2'd1,
    ST_MEM_READ   = 2'd2
  } state_e;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
    logic [BLK_W-1:0] data;
  } line_t;

  function automatic logic [7:0] sel_byte(input logic [BLK_W-1:0] blk,
                                          input logic [OFFSET_W-1:0] off);
    return blk[{off, 3'b000} +: 8];
  endfunction

  function automatic logic [BLK_W-1:0] put_byte(input logic [BLK_W-1:0] blk,
                                                input logic [OFFSET_W-1:0] off,
                                                input logic [7:0] b);
    logic [BLK_W-1:0] r;
    r = blk;
    r[{off, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/dcache_tag_cmp.sv
// Valid-qualified tag comparison for the indexed cache line.
module dcache_tag_cmp
  import dcache_pkg::*;
(
  input  logic             valid_i,
  input  logic [TAG_W-1:0] line_tag_i,
  input  logic [TAG_W-1:0] addr_tag_i,
  output logic             hit_o
);

  assign hit_o = valid_i & (line_tag_i == addr_tag_i);

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Define DCACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);

  line_t  lines_q [NUM_LINES];
  state_e state_q;
  logic   busy_seen_q;

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  addr_idx;
  logic [OFFSET_W-1:0] addr_off;
  line_t               cur_line;
  line_t               fill_line;
  logic                hit;
  logic                req;
  logic                idle_req;
  logic                mem_done;
  logic                fill_done;

  assign addr_tag = ADDRESS[7:5];
  assign addr_idx = ADDRESS[4:2];
  assign addr_off = ADDRESS[1:0];
  assign cur_line = lines_q[addr_idx];

  dcache_tag_cmp u_tag_cmp (
    .valid_i    (cur_line.valid),
    .line_tag_i (cur_line.tag),
    .addr_tag_i (addr_tag),
    .hit_o      (hit)
  );

  assign req       = READ | WRITE;
  assign idle_req  = req & (state_q == ST_IDLE);
  // A memory transfer ends only after busy has been seen high, then low.
  assign mem_done  = busy_seen_q & ~MEM_BUSYWAIT;
  assign fill_done = (state_q == ST_MEM_READ) & mem_done;

  assign READDATA = sel_byte(cur_line.data, addr_off);
  assign BUSYWAIT = req & ~((state_q == ST_IDLE) & hit);

  always_comb begin
    fill_line       = '0;
    fill_line.valid = 1'b1;
    fill_line.tag   = addr_tag;
    fill_line.data  = MEM_READDATA;
  end

  always_comb begin
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state_q)
      ST_WRITE_BACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {cur_line.tag, addr_idx};
        MEM_WRITEDATA = cur_line.data;
      end
      ST_MEM_READ: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = ADDRESS[7:2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      busy_seen_q <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) lines_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            if (hit) begin
              // Simultaneous READ and WRITE is a store.
              if (WRITE) begin
                lines_q[addr_idx].data  <= put_byte(cur_line.data, addr_off, WRITEDATA);
                lines_q[addr_idx].dirty <= 1'b1;
              end
            end else begin
              busy_seen_q <= 1'b0;
              state_q     <= (cur_line.valid & cur_line.dirty) ? ST_WRITE_BACK : ST_MEM_READ;
            end
          end
        end
        ST_WRITE_BACK: begin
          if (MEM_BUSYWAIT) begin
            busy_seen_q <= 1'b1;
          end else if (busy_seen_q) begin
            busy_seen_q <= 1'b0;
            state_q     <= ST_MEM_READ;
          end
        end
        ST_MEM_READ: begin
          if (MEM_BUSYWAIT) begin
            busy_seen_q <= 1'b1;
          end else if (busy_seen_q) begin
            busy_seen_q       <= 1'b0;
            lines_q[addr_idx] <= fill_line;
            state_q           <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;
  logic        post_fill_q;

  // The hit that retires a miss is not a cache hit from the CPU's view.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      post_fill_q <= 1'b0;
    end else begin
      post_fill_q <= fill_done;
      if (idle_req && hit && !post_fill_q && hit_cnt_q != 16'hFFFF)
        hit_cnt_q <= hit_cnt_q + 16'd1;
      if (idle_req && !hit && miss_cnt_q != 16'hFFFF)
        miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`else
  logic unused_fill_done;
  assign unused_fill_done = fill_done;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller (stats checks under DCACHE_STATS_EN).
module tb_dcache_controller;

  logic        CLK = 1'b0;
  logic        RESET, READ, WRITE, MEM_BUSYWAIT;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;
`ifdef DCACHE_STATS_EN
  logic [15:0] HIT_COUNT, MISS_COUNT;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  dcache_controller dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  task automatic tick();
    @(negedge CLK);
  endtask

  // Hold memory busy for n cycles, then release with data; returns 1ns after the completing edge's negedge.
  task automatic mem_serve(input int n, input logic [31:0] d);
    MEM_BUSYWAIT = 1'b1;
    repeat (n) tick();
    MEM_BUSYWAIT = 1'b0;
    MEM_READDATA = d;
    tick(); #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; READ = 0; WRITE = 0; ADDRESS = 0; WRITEDATA = 0;
    MEM_BUSYWAIT = 0; MEM_READDATA = 0;
    repeat (2) tick();
    RESET = 1'b0; #1;
    n_cmp++; if (READDATA !== 8'h00) begin n_bad++; $display("FAIL rst_readdata got %h want 00", READDATA); end
    n_cmp++; if (BUSYWAIT !== 1'b0) begin n_bad++; $display("FAIL rst_busywait got %b want 0", BUSYWAIT); end
    n_cmp++; if ({MEM_READ, MEM_WRITE} !== 2'b00) begin n_bad++; $display("FAIL rst_strobes got %b want 00", {MEM_READ, MEM_WRITE}); end
    n_cmp++; if (MEM_ADDRESS !== 6'h00) begin n_bad++; $display("FAIL rst_memaddr got %h want 00", MEM_ADDRESS); end
    n_cmp++; if (MEM_WRITEDATA !== 32'h0) begin n_bad++; $display("FAIL rst_memwdata got %h want 0", MEM_WRITEDATA); end
  endtask

  task automatic test_clean_miss();
    tick(); READ = 1; ADDRESS = 8'h05; #1;
    n_cmp++; if (BUSYWAIT !== 1'b1) begin n_bad++; $display("FAIL cm_busy_idle got %b want 1", BUSYWAIT); end
    n_cmp++; if (MEM_READ !== 1'b0) begin n_bad++; $display("FAIL cm_memread_idle got %b want 0", MEM_READ); end
    tick(); #1;
    n_cmp++; if (MEM_READ !== 1'b1 || MEM_WRITE !== 1'b0) begin n_bad++; $display("FAIL cm_strobes got %b%b want 10", MEM_READ, MEM_WRITE); end
    n_cmp++; if (MEM_ADDRESS !== 6'h01) begin n_bad++; $display("FAIL cm_memaddr got %h want 01", MEM_ADDRESS); end
    MEM_BUSYWAIT = 1'b1;
    repeat (5) tick();
    #1;
    n_cmp++; if (MEM_READ !== 1'b1 || BUSYWAIT !== 1'b1) begin n_bad++; $display("FAIL cm_still_busy got %b%b want 11", MEM_READ, BUSYWAIT); end
    MEM_BUSYWAIT = 1'b0; MEM_READDATA = 32'hDDCCBBAA;
    tick(); #1;
    n_cmp++; if (BUSYWAIT !== 1'b0) begin n_bad++; $display("FAIL cm_busy_after got %b want 0", BUSYWAIT); end
    n_cmp++; if (READDATA !== 8'hBB) begin n_bad++; $display("FAIL cm_readdata got %h want BB", READDATA); end
    n_cmp++; if (MEM_READ !== 1'b0) begin n_bad++; $display("FAIL cm_memread_drop got %b want 0", MEM_READ); end
  endtask

  task automatic test_write_hit();
    tick(); READ = 0; WRITE = 1; WRITEDATA = 8'h5A; ADDRESS = 8'h05; #1;
    n_cmp++; if (BUSYWAIT !== 1'b0) begin n_bad++; $display("FAIL wh_busy got %b want 0", BUSYWAIT); end
    tick(); WRITE = 0; READ = 1; #1;
    n_cmp++; if (READDATA !== 8'h5A) begin n_bad++; $display("FAIL wh_readback got %h want 5A", READDATA); end
    ADDRESS = 8'h04; #1;
    n_cmp++; if (READDATA !== 8'hAA) begin n_bad++; $display("FAIL wh_off0 got %h want AA", READDATA); end
    ADDRESS = 8'h07; #1;
    n_cmp++; if (READDATA !== 8'hDD) begin n_bad++; $display("FAIL wh_off3 got %h want DD", READDATA); end
  endtask

  task automatic test_dirty_miss();
    ADDRESS = 8'h25; #1;
    n_cmp++; if (BUSYWAIT !== 1'b1) begin n_bad++; $display("FAIL dm_busy got %b want 1", BUSYWAIT); end
    tick(); #1;
    n_cmp++; if (MEM_WRITE !== 1'b1 || MEM_READ !== 1'b0) begin n_bad++; $display("FAIL dm_wb_strobes got %b%b want 01", MEM_READ, MEM_WRITE); end
    n_cmp++; if (MEM_ADDRESS !== 6'h01) begin n_bad++; $display("FAIL dm_wb_addr got %h want 01", MEM_ADDRESS); end
    n_cmp++; if (MEM_WRITEDATA !== 32'hDDCC5AAA) begin n_bad++; $display("FAIL dm_wb_data got %h want DDCC5AAA", MEM_WRITEDATA); end
    mem_serve(2, 32'h0);
    n_cmp++; if (MEM_READ !== 1'b1 || MEM_WRITE !== 1'b0) begin n_bad++; $display("FAIL dm_mr_strobes got %b%b want 10", MEM_READ, MEM_WRITE); end
    n_cmp++; if (MEM_ADDRESS !== 6'h09) begin n_bad++; $display("FAIL dm_mr_addr got %h want 09", MEM_ADDRESS); end
    n_cmp++; if (MEM_WRITEDATA !== 32'h0) begin n_bad++; $display("FAIL dm_mr_wdata got %h want 0", MEM_WRITEDATA); end
    tick(); #1;
    n_cmp++; if (MEM_READ !== 1'b1) begin n_bad++; $display("FAIL dm_no_busy_pulse got %b want 1", MEM_READ); end
    mem_serve(3, 32'h11223344);
    n_cmp++; if (BUSYWAIT !== 1'b0) begin n_bad++; $display("FAIL dm_busy_after got %b want 0", BUSYWAIT); end
    n_cmp++; if (READDATA !== 8'h33) begin n_bad++; $display("FAIL dm_readdata got %h want 33", READDATA); end
  endtask

  task automatic test_reset_mid();
    ADDRESS = 8'h05; #1;
    n_cmp++; if (BUSYWAIT !== 1'b1) begin n_bad++; $display("FAIL rm_busy got %b want 1", BUSYWAIT); end
    tick(); #1;
    n_cmp++; if (MEM_READ !== 1'b1) begin n_bad++; $display("FAIL rm_memread got %b want 1", MEM_READ); end
    MEM_BUSYWAIT = 1'b1;
    tick(); RESET = 1'b1;
    tick(); #1;
    n_cmp++; if (MEM_READ !== 1'b0) begin n_bad++; $display("FAIL rm_abandon got %b want 0", MEM_READ); end
    MEM_BUSYWAIT = 1'b0; RESET = 1'b0; ADDRESS = 8'h25; #1;
    n_cmp++; if (BUSYWAIT !== 1'b1) begin n_bad++; $display("FAIL rm_invalidated got %b want 1", BUSYWAIT); end
    n_cmp++; if (READDATA !== 8'h00) begin n_bad++; $display("FAIL rm_data_cleared got %h want 00", READDATA); end
    tick(); #1;
    n_cmp++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'h09) begin n_bad++; $display("FAIL rm_refetch got %b/%h want 1/09", MEM_READ, MEM_ADDRESS); end
    mem_serve(1, 32'h99887766);
    n_cmp++; if (BUSYWAIT !== 1'b0 || READDATA !== 8'h77) begin n_bad++; $display("FAIL rm_fill got %b/%h want 0/77", BUSYWAIT, READDATA); end
  endtask

  task automatic test_read_write_both();
    ADDRESS = 8'h27; WRITE = 1; WRITEDATA = 8'hC3; #1;
    n_cmp++; if (BUSYWAIT !== 1'b0) begin n_bad++; $display("FAIL rw_busy got %b want 0", BUSYWAIT); end
    tick(); WRITE = 0; #1;
    n_cmp++; if (READDATA !== 8'hC3) begin n_bad++; $display("FAIL rw_written got %h want C3", READDATA); end
    ADDRESS = 8'h05; #1;
    tick(); #1;
    n_cmp++; if (MEM_WRITE !== 1'b1 || MEM_ADDRESS !== 6'h09) begin n_bad++; $display("FAIL rw_dirty_wb got %b/%h want 1/09", MEM_WRITE, MEM_ADDRESS); end
    n_cmp++; if (MEM_WRITEDATA !== 32'hC3887766) begin n_bad++; $display("FAIL rw_wb_data got %h want C3887766", MEM_WRITEDATA); end
    mem_serve(1, 32'h0);
    n_cmp++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'h01) begin n_bad++; $display("FAIL rw_mr got %b/%h want 1/01", MEM_READ, MEM_ADDRESS); end
    mem_serve(1, 32'hDDCC5AAA);
    n_cmp++; if (BUSYWAIT !== 1'b0 || READDATA !== 8'h5A) begin n_bad++; $display("FAIL rw_refill got %b/%h want 0/5A", BUSYWAIT, READDATA); end
  endtask

  task automatic test_drop_request();
    ADDRESS = 8'h1C; #1;
    n_cmp++; if (BUSYWAIT !== 1'b1) begin n_bad++; $display("FAIL dr_busy got %b want 1", BUSYWAIT); end
    tick(); READ = 0; #1;
    n_cmp++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'h07 || BUSYWAIT !== 1'b0) begin n_bad++; $display("FAIL dr_continue got %b/%h/%b want 1/07/0", MEM_READ, MEM_ADDRESS, BUSYWAIT); end
    mem_serve(2, 32'hCAFEF00D);
    n_cmp++; if (MEM_READ !== 1'b0) begin n_bad++; $display("FAIL dr_done got %b want 0", MEM_READ); end
    READ = 1; #1;
    n_cmp++; if (BUSYWAIT !== 1'b0 || READDATA !== 8'h0D) begin n_bad++; $display("FAIL dr_hit got %b/%h want 0/0D", BUSYWAIT, READDATA); end
    tick(); READ = 0;
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    RESET = 1'b1; tick(); RESET = 1'b0; #1;
    n_cmp++; if (HIT_COUNT !== 16'd0 || MISS_COUNT !== 16'd0) begin n_bad++; $display("FAIL st_reset got %0d/%0d want 0/0", HIT_COUNT, MISS_COUNT); end
    ADDRESS = 8'h00; READ = 1;
    tick(); #1;
    n_cmp++; if (MISS_COUNT !== 16'd1) begin n_bad++; $display("FAIL st_miss1 got %0d want 1", MISS_COUNT); end
    mem_serve(1, 32'h44332211);
    repeat (4) tick();
    ADDRESS = 8'h20;
    tick(); #1;
    n_cmp++; if (MISS_COUNT !== 16'd2) begin n_bad++; $display("FAIL st_miss2 got %0d want 2", MISS_COUNT); end
    n_cmp++; if (HIT_COUNT !== 16'd3) begin n_bad++; $display("FAIL st_hits got %0d want 3", HIT_COUNT); end
    READ = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_clean_miss();
    test_write_hit();
    test_dirty_miss();
    test_reset_mid();
    test_read_write_both();
    test_drop_request();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
